// File: rtl/bolt_fire_ctrl.sv
// rtl/bolt_fire_ctrl.sv - bolt fire controller: shot lifetime, cooldown and shot/hit statistics (option macro: AUTO_FIRE_EN)
module bolt_fire_ctrl #(
    parameter int Y_MIN             = 0,
    parameter int Y_MAX             = 479,
    parameter int ARM_CYCLES        = 2,
    parameter int COOLDOWN_FRAMES   = 8,
    parameter int MAX_FLIGHT_FRAMES = 60
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        gameEnable,
    input  logic        fireReq,
    input  logic [10:0] boltY,
    input  logic        collision,
    input  logic        clearCnt,
    output logic        shootCmd,
    output logic        ready,
    output logic        hitPulse,
    output logic [7:0]  shotCount,
    output logic [7:0]  hitCount
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARM      = 2'd1,
        FLY      = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    localparam logic [15:0] ARM_L = 16'(ARM_CYCLES);
    localparam logic [15:0] CD_L  = 16'(COOLDOWN_FRAMES);
    localparam logic [15:0] MAX_L = 16'(MAX_FLIGHT_FRAMES);
    localparam logic [10:0] YMIN_L = 11'(Y_MIN);
    localparam logic [10:0] YMAX_L = 11'(Y_MAX);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        fire_prev;
    logic        start_shot;
    logic        shot_inc;
    logic        hit_now;
    logic        off_screen;
    logic [11:0] below_diff;
    logic [11:0] above_diff;

    // Sign bit of a widened subtraction gives the unsigned range test without constant-compare corner cases
    assign below_diff = {1'b0, boltY} - {1'b0, YMIN_L};
    assign above_diff = {1'b0, YMAX_L} - {1'b0, boltY};
    assign off_screen = below_diff[11] | above_diff[11];

`ifdef AUTO_FIRE_EN
    assign start_shot = fireReq;
`else
    assign start_shot = fireReq & ~fire_prev;
`endif

    assign shootCmd = (state_q == ARM) || (state_q == FLY);
    assign ready    = (state_q == IDLE) && gameEnable;

    // State register, shared phase counter, fire edge register and hit pulse
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            fire_prev <= 1'b0;
            hitPulse  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fire_prev <= fireReq;
            hitPulse  <= hit_now;
        end
    end

    // Next-state logic; the counter restarts from zero on every state change
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shot_inc = 1'b0;
        hit_now  = 1'b0;
        if (!gameEnable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_shot) begin
                        state_d  = ARM;
                        cnt_d    = '0;
                        shot_inc = 1'b1;
                    end
                end
                ARM: begin
                    if (cnt_q == ARM_L - 16'd1) begin
                        state_d = FLY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                FLY: begin
                    if (collision) begin
                        state_d = COOLDOWN;
                        cnt_d   = '0;
                        hit_now = 1'b1;
                    end else if (off_screen) begin
                        state_d = COOLDOWN;
                        cnt_d   = '0;
                    end else if (startOfFrame) begin
                        if (cnt_q + 16'd1 == MAX_L) begin
                            state_d = COOLDOWN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end
                COOLDOWN: begin
                    if (startOfFrame) begin
                        if (cnt_q + 16'd1 == CD_L) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Saturating statistics; clearCnt wins over a same-clock increment
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            shotCount <= '0;
            hitCount  <= '0;
        end else if (clearCnt) begin
            shotCount <= '0;
            hitCount  <= '0;
        end else begin
            if (shot_inc && shotCount != 8'hFF) shotCount <= shotCount + 8'd1;
            if (hit_now && hitCount != 8'hFF)   hitCount  <= hitCount + 8'd1;
        end
    end

endmodule

// File: tb/tb_bolt_fire_ctrl.sv
// tb/tb_bolt_fire_ctrl.sv - randomized self-checking bench for bolt_fire_ctrl against a frame-level reference model
module tb_bolt_fire_ctrl;

    localparam int YMIN = 0;
    localparam int YMAX = 479;
    localparam int ARMC = 2;
    localparam int CDF  = 8;
    localparam int MAXF = 60;

    localparam int P_IDLE = 0;
    localparam int P_ARM  = 1;
    localparam int P_FLY  = 2;
    localparam int P_COOL = 3;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic        gameEnable;
    logic        fireReq;
    logic [10:0] boltY;
    logic        collision;
    logic        clearCnt;
    logic        shootCmd;
    logic        ready;
    logic        hitPulse;
    logic [7:0]  shotCount;
    logic [7:0]  hitCount;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n   = 0;
    int sof_per = 2;

    // reference model: phase plus budgets left in that phase
    int m_phase;
    int m_arm_left;
    int m_frames;
    int m_cool_left;
    int m_shots;
    int m_hits;
    int m_hp;
    int m_prev;

    bolt_fire_ctrl #(
        .Y_MIN(YMIN), .Y_MAX(YMAX), .ARM_CYCLES(ARMC),
        .COOLDOWN_FRAMES(CDF), .MAX_FLIGHT_FRAMES(MAXF)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .gameEnable(gameEnable), .fireReq(fireReq), .boltY(boltY),
        .collision(collision), .clearCnt(clearCnt), .shootCmd(shootCmd),
        .ready(ready), .hitPulse(hitPulse), .shotCount(shotCount),
        .hitCount(hitCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_arm_left = 0; m_frames = 0; m_cool_left = 0;
        m_shots = 0; m_hits = 0; m_hp = 0; m_prev = 0;
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    // One clock of the specification's rules applied to the current inputs
    task automatic model_clock();
        int  start;
        int  gone;
        int  new_shot;
        int  new_hit;
        new_shot = 0; new_hit = 0; m_hp = 0;
`ifdef AUTO_FIRE_EN
        start = fireReq;
`else
        start = (fireReq && !m_prev) ? 1 : 0;
`endif
        gone = (int'(boltY) < YMIN || int'(boltY) > YMAX) ? 1 : 0;
        if (!gameEnable) begin
            m_phase = P_IDLE;
        end else if (m_phase == P_IDLE) begin
            if (start != 0) begin
                m_phase = P_ARM; m_arm_left = ARMC; new_shot = 1;
            end
        end else if (m_phase == P_ARM) begin
            m_arm_left--;
            if (m_arm_left == 0) begin
                m_phase = P_FLY; m_frames = 0;
            end
        end else if (m_phase == P_FLY) begin
            if (collision) begin
                m_phase = P_COOL; m_cool_left = CDF; new_hit = 1; m_hp = 1;
            end else if (gone != 0) begin
                m_phase = P_COOL; m_cool_left = CDF;
            end else if (startOfFrame) begin
                m_frames++;
                if (m_frames == MAXF) begin
                    m_phase = P_COOL; m_cool_left = CDF;
                end
            end
        end else begin
            if (startOfFrame) begin
                m_cool_left--;
                if (m_cool_left == 0) m_phase = P_IDLE;
            end
        end
        if (clearCnt) begin
            m_shots = 0; m_hits = 0;
        end else begin
            if (new_shot != 0) m_shots = sat_inc(m_shots);
            if (new_hit != 0)  m_hits  = sat_inc(m_hits);
        end
        m_prev = fireReq;
    endtask

    task automatic check_outputs();
        chk("shootCmd",  int'(shootCmd),  (m_phase == P_ARM || m_phase == P_FLY) ? 1 : 0);
        chk("ready",     int'(ready),     (m_phase == P_IDLE && gameEnable) ? 1 : 0);
        chk("hitPulse",  int'(hitPulse),  m_hp);
        chk("shotCount", int'(shotCount), m_shots);
        chk("hitCount",  int'(hitCount),  m_hits);
    endtask

    task automatic cyc();
        if (sof_per == 0) startOfFrame = ($urandom_range(0, 3) == 0);
        else              startOfFrame = ((cyc_n % sof_per) == 0);
        @(posedge clk);
        model_clock();
        #1;
        check_outputs();
        cyc_n++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_phase(input string tag, input int p, input int limit);
        int k;
        k = 0;
        while (m_phase != p && k < limit) begin
            cyc();
            k++;
        end
        chk(tag, m_phase, p);
    endtask

    task automatic fire();
        fireReq = 1'b0; cyc();
        fireReq = 1'b1; cyc();
        fireReq = 1'b0;
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; gameEnable = 1'b1; fireReq = 1'b0;
        boltY = 11'd300; collision = 1'b0; clearCnt = 1'b0;
        model_reset();
        #12;
        check_outputs();
        resetN = 1'b1;

        // single shot ending in a hit, then full cooldown
        fire();
        chk("armed_shot", int'(shootCmd), 1);
        wait_phase("reach_fly_hit", P_FLY, 10);
        collision = 1'b1; cyc(); collision = 1'b0;
        chk("hit_drop", int'(shootCmd), 0);
        cyc();
        wait_phase("cool_done", P_IDLE, 100);

        // negative wrap Y leaves the screen
        fire();
        wait_phase("reach_fly_wrap", P_FLY, 10);
        boltY = 11'd2030; cyc();
        chk("wrap_cool", m_phase, P_COOL);
        boltY = 11'd479;
        wait_phase("cool_done2", P_IDLE, 100);

        // flight timeout with boltY held on screen
        boltY = 11'd200; sof_per = 3;
        fire();
        wait_phase("timeout", P_COOL, 400);
        wait_phase("cool_done3", P_IDLE, 100);

        // held fire button for 30 frames
        fireReq = 1'b1; run(90); fireReq = 1'b0;
        wait_phase("hold_end", P_IDLE, 400);

        // saturate hit counter, then clear together with a collision
        sof_per = 2; boltY = 11'd300;
        for (int i = 0; i < 257; i++) begin
            fire();
            wait_phase("sat_fly", P_FLY, 10);
            if (i == 256) clearCnt = 1'b1;
            collision = 1'b1; cyc(); collision = 1'b0; clearCnt = 1'b0;
            wait_phase("sat_idle", P_IDLE, 100);
        end

        // gameEnable drop mid-flight
        fire();
        wait_phase("ge_fly", P_FLY, 10);
        gameEnable = 1'b0; run(3); gameEnable = 1'b1;

        // randomized traffic
        sof_per = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 4) == 0) fireReq = ~fireReq;
            collision  = ($urandom_range(0, 19) == 0);
            clearCnt   = ($urandom_range(0, 99) == 0);
            gameEnable = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 29) == 0) boltY = 11'($urandom_range(0, 2047));
            else                            boltY = 11'($urandom_range(0, 479));
            cyc();
        end

        // asynchronous reset mid-flight
        collision = 1'b0; clearCnt = 1'b0; gameEnable = 1'b1; boltY = 11'd250; sof_per = 2;
        wait_phase("pre_rst_idle", P_IDLE, 400);
        fire();
        wait_phase("rst_fly", P_FLY, 10);
        #1 resetN = 1'b0;
        #1;
        chk("async_rst_shoot", int'(shootCmd), 0);
        model_reset();
        check_outputs();
        #1 resetN = 1'b1;
        run(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
